gray_decoder_top: RTL and testbench

//  Top level of the Gray-code display path. Takes a 4-bit Gray code from board switches and converts it to binary 0..15.

---
 rtl/gray_decoder_top.sv | 87 ++++++++
 tb/tb_gray_decoder_top.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_decoder_top.sv
// Gray-code switch input to one 7-segment digit (units or decades of the 0..15 value).
// Both async inputs share a matched synchroniser depth, so a digit and its select always arrive together.
module gray_decoder_top #(
   parameter int SYNC_STAGES    = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] gray_code,
   input  logic       show_decades,
   output logic [6:0] display_code
);

   localparam logic [6:0] SEG_BLANK_AL = 7'b1111111;
   localparam logic [6:0] SEG_BLANK    = SEG_ACTIVE_LOW ? SEG_BLANK_AL : ~SEG_BLANK_AL;

   logic [SYNC_STAGES-1:0][3:0] gray_sync_q;
   logic [SYNC_STAGES-1:0]      sel_sync_q;
   logic [6:0]                  display_code_q;
   logic [6:0]                  display_code_d;

   logic [3:0] gray_s;
   logic [3:0] bin;
   logic       is_high;
   logic [3:0] units;
   logic [3:0] decades;
   logic       show_units;
   logic [3:0] digit;
   logic [6:0] seg_al;

   // Index 0 is the metastability-catching stage; the last index feeds the decoder.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gray_sync_q <= '0;
         sel_sync_q  <= '0;
      end else begin
         // NOTE: non-blocking so every stage samples the previous stage's old value in the same edge.
         gray_sync_q <= {gray_sync_q[SYNC_STAGES-2:0], gray_code};
         sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], show_decades};
      end
   end

   assign gray_s = gray_sync_q[SYNC_STAGES-1];

   // Each binary bit is the XOR of all Gray bits at and above it.
   assign bin[3] = gray_s[3];
   assign bin[2] = ^gray_s[3:2];
   assign bin[1] = ^gray_s[3:1];
   assign bin[0] = ^gray_s[3:0];

   assign is_high    = (bin >= 4'd10);
   assign units      = is_high ? (bin - 4'd10) : bin;
   assign decades    = {3'b000, is_high};
   assign show_units = ~sel_sync_q[SYNC_STAGES-1];
   assign digit      = show_units ? units : decades;

   always_comb begin
      // NOTE: default first so every path assigns seg_al and no latch is inferred.
      seg_al = SEG_BLANK_AL;
      unique case (digit)
         4'd0:    seg_al = 7'b1000000;
         4'd1:    seg_al = 7'b1111001;
         4'd2:    seg_al = 7'b0100100;
         4'd3:    seg_al = 7'b0110000;
         4'd4:    seg_al = 7'b0011001;
         4'd5:    seg_al = 7'b0010010;
         4'd6:    seg_al = 7'b0000010;
         4'd7:    seg_al = 7'b1111000;
         4'd8:    seg_al = 7'b0000000;
         4'd9:    seg_al = 7'b0010000;
         default: seg_al = SEG_BLANK_AL;
      endcase
   end

   assign display_code_d = SEG_ACTIVE_LOW ? seg_al : ~seg_al;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display_code_q <= SEG_BLANK;
      end else begin
         display_code_q <= display_code_d;
      end
   end

   assign display_code = display_code_q;

endmodule

// File: tb/tb_gray_decoder_top.sv
// Randomised and directed bench for gray_decoder_top against an arithmetic reference model.
module tb_gray_decoder_top;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] gray_code;
   logic       show_decades;
   logic [6:0] display_code;

   int checks = 0;
   int errors = 0;
   logic [6:0] cur_exp;

   localparam logic [6:0] BLANK = 7'b1111111;

   gray_decoder_top #(
      .SYNC_STAGES    (2),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .gray_code    (gray_code),
      .show_decades (show_decades),
      .display_code (display_code)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return BLANK;
      endcase
   endfunction

   // Find the value whose Gray encoding n^(n>>1) matches, then split it in decimal.
   function automatic logic [6:0] model(input logic [3:0] g, input logic sel);
      int v = 0;
      for (int n = 0; n < 16; n++)
         if (4'(n ^ (n >> 1)) == g) v = n;
      return sel ? seg_of(v / 10) : seg_of(v % 10);
   endfunction

   // Drives one input frame and samples the display after each of the next three edges.
   task automatic drive_frame(input logic [3:0] g, input logic s,
                              output logic [6:0] o0, output logic [6:0] o1, output logic [6:0] o2);
      @(negedge clk);
      gray_code    = g;
      show_decades = s;
      @(posedge clk); #1 o0 = display_code;
      @(posedge clk); #1 o1 = display_code;
      @(posedge clk); #1 o2 = display_code;
   endtask

   task automatic test_reset;
      logic [6:0] o0, o1, o2;
      rst = 1'b1;
      gray_code = 4'b0000;
      show_decades = 1'b0;
      #3;
      checks++;
      if (display_code !== BLANK) begin
         errors++;
         $display("FAIL reset_blank: got %b expected %b", display_code, BLANK);
      end
      @(posedge clk); #1;
      checks++;
      if (dut.show_units !== 1'b1) begin
         errors++;
         $display("FAIL reset_show_units: got %b expected 1", dut.show_units);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_frame(4'b0000, 1'b0, o0, o1, o2);
      checks++;
      if (o2 !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", o2, 7'b1000000);
      end
      cur_exp = 7'b1000000;
   endtask

   task automatic test_units_sweep;
      logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};
      logic [6:0] o0, o1, o2, exp;
      for (int i = 0; i < 8; i++) begin
         exp = seg_of(i);
         drive_frame(seq[i], 1'b0, o0, o1, o2);
         checks++;
         if (o0 !== cur_exp || o1 !== cur_exp) begin
            errors++;
            $display("FAIL sweep_latency[%0d]: got %b,%b expected %b", i, o0, o1, cur_exp);
         end
         checks++;
         if (o2 !== exp) begin
            errors++;
            $display("FAIL sweep_digit[%0d]: got %b expected %b", i, o2, exp);
         end
         cur_exp = exp;
      end
   endtask

   task automatic test_units_upper;
      logic [3:0] seq [5] = '{4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1000};
      logic [6:0] want [5] = '{7'b0000000, 7'b0010000, 7'b1000000, 7'b1111001, 7'b0010010};
      logic [6:0] o0, o1, o2;
      for (int i = 0; i < 5; i++) begin
         drive_frame(seq[i], 1'b0, o0, o1, o2);
         checks++;
         if (o2 !== want[i]) begin
            errors++;
            $display("FAIL upper_units[%0d]: got %b expected %b", i, o2, want[i]);
         end
         cur_exp = want[i];
      end
   endtask

   task automatic test_decades;
      logic [6:0] o0, o1, o2, exp;
      for (int v = 0; v < 16; v++) begin
         exp = (v >= 10) ? 7'b1111001 : 7'b1000000;
         drive_frame(4'(v ^ (v >> 1)), 1'b1, o0, o1, o2);
         checks++;
         if (o2 !== exp) begin
            errors++;
            $display("FAIL decades[%0d]: got %b expected %b", v, o2, exp);
         end
         cur_exp = exp;
      end
   endtask

   task automatic test_sel_toggle;
      logic [6:0] o0, o1, o2;
      drive_frame(4'b1001, 1'b0, o0, o1, o2);
      checks++;
      if (o2 !== 7'b0011001 || dut.show_units !== 1'b1) begin
         errors++;
         $display("FAIL toggle_units: got %b/%b expected %b/1", o2, dut.show_units, 7'b0011001);
      end
      @(negedge clk);
      show_decades = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.show_units !== 1'b1) begin
         errors++;
         $display("FAIL toggle_probe_early: got %b expected 1", dut.show_units);
      end
      @(posedge clk); #1;
      checks++;
      if (dut.show_units !== 1'b0 || display_code !== 7'b0011001) begin
         errors++;
         $display("FAIL toggle_probe: got %b/%b expected 0/%b", dut.show_units, display_code, 7'b0011001);
      end
      @(posedge clk); #1;
      checks++;
      if (display_code !== 7'b1111001) begin
         errors++;
         $display("FAIL toggle_decades: got %b expected %b", display_code, 7'b1111001);
      end
      cur_exp = 7'b1111001;
   endtask

   // Both inputs change together; every intermediate frame must be wholly old or wholly new.
   task automatic test_simultaneous;
      logic [6:0] o0, o1, o2, exp;
      logic [3:0] g;
      logic       s;
      for (int i = 0; i < 30; i++) begin
         g = 4'($urandom_range(0, 15));
         s = 1'($urandom_range(0, 1));
         exp = model(g, s);
         drive_frame(g, s, o0, o1, o2);
         checks++;
         if (o0 !== cur_exp || o1 !== cur_exp || o2 !== exp) begin
            errors++;
            $display("FAIL simultaneous[%0d] g=%b s=%b: got %b,%b,%b expected %b,%b,%b",
                     i, g, s, o0, o1, o2, cur_exp, cur_exp, exp);
         end
         cur_exp = exp;
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] hg [40];
      logic       hs [40];
      logic [6:0] exp;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         hg[k] = 4'($urandom_range(0, 15));
         hs[k] = 1'($urandom_range(0, 1));
         gray_code    = hg[k];
         show_decades = hs[k];
         @(posedge clk); #1;
         if (k >= 2) begin
            exp = model(hg[k-2], hs[k-2]);
            checks++;
            if (display_code !== exp) begin
               errors++;
               $display("FAIL back_to_back[%0d]: got %b expected %b", k, display_code, exp);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [6:0] o0, o1, o2, exp;
      logic [3:0] g;
      logic       s;
      drive_frame(4'b0100, 1'b0, o0, o1, o2);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      checks++;
      if (display_code !== BLANK) begin
         errors++;
         $display("FAIL midreset_async: got %b expected %b", display_code, BLANK);
      end
      @(posedge clk); #1;
      checks++;
      if (display_code !== BLANK) begin
         errors++;
         $display("FAIL midreset_hold: got %b expected %b", display_code, BLANK);
      end
      g = 4'($urandom_range(1, 15));
      s = 1'($urandom_range(0, 1));
      exp = model(g, s);
      @(negedge clk);
      rst = 1'b0;
      gray_code    = g;
      show_decades = s;
      @(posedge clk); #1 o0 = display_code;
      @(posedge clk); #1 o1 = display_code;
      @(posedge clk); #1 o2 = display_code;
      checks++;
      if (o0 !== 7'b1000000 || o1 !== 7'b1000000) begin
         errors++;
         $display("FAIL midreset_cleared_sync: got %b,%b expected %b", o0, o1, 7'b1000000);
      end
      checks++;
      if (o2 !== exp) begin
         errors++;
         $display("FAIL midreset_recover g=%b s=%b: got %b expected %b", g, s, o2, exp);
      end
      cur_exp = exp;
   endtask

   initial begin
      test_reset();
      test_units_sweep();
      test_units_upper();
      test_decades();
      test_sel_toggle();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
